// File: rtl/mdio_pkg.sv
// MDIO master shared definitions: FSM state encoding, i_cmd field map
// (wire order, LSB first), opcodes and frame geometry.
package mdio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_FRAME    = 2'd2
  } state_t;

  localparam int unsigned FRAME_LEN            = 32;
  localparam int unsigned PREAMBLE_LEN_DEFAULT = 32;
  localparam int unsigned BIT_IDX_W            = 5;

  // Field positions/widths inside the 32-bit frame word
  localparam int unsigned ST_POS    = 0;
  localparam int unsigned ST_W      = 2;
  localparam int unsigned OP_POS    = 2;
  localparam int unsigned OP_W      = 2;
  localparam int unsigned PHYAD_POS = 4;
  localparam int unsigned PHYAD_W   = 5;
  localparam int unsigned REGAD_POS = 9;
  localparam int unsigned REGAD_W   = 5;
  localparam int unsigned TA_POS    = 14;
  localparam int unsigned TA_W      = 2;
  localparam int unsigned DATA_POS  = 16;
  localparam int unsigned DATA_W    = 16;

  // OP field as stored in i_cmd[3:2]; wire "10" is a read
  localparam logic [OP_W-1:0] OP_READ  = 2'b01;
  localparam logic [OP_W-1:0] OP_WRITE = 2'b10;

  function automatic logic is_read(input logic [FRAME_LEN-1:0] cmd);
    return cmd[OP_POS +: OP_W] == OP_READ;
  endfunction

endpackage

// File: rtl/mdio_io.sv
// MDIO pad: drives the shared line when enabled, otherwise releases it;
// returns the line level for sampling.
//   drive_en  : 1 = drive drive_bit onto mdio, 0 = high impedance
//   drive_bit : value driven while enabled
//   sample    : current line level
//   mdio      : bidirectional MDIO line (external pull-up)
module mdio_io (
  input  logic drive_en,
  input  logic drive_bit,
  output logic sample,
  inout  wire  mdio
);

  assign mdio   = drive_en ? drive_bit : 1'bz;
  assign sample = mdio;

endmodule

// File: rtl/mdio.sv
// MDIO management master. One bit-time per i_clk cycle (i_clk is MDC).
// Accepts a 32-bit frame word in IDLE, optionally sends a preamble of ones,
// then shifts the frame out LSB first. Read frames release the line from the
// turnaround onward and capture bits 16..31 into o_r_register_data.
// Build option: define MDIO_PREAMBLE_EN to send PREAMBLE_LEN preamble ones;
// without it the frame starts right after the accept edge.
//   i_clk               : clock / MDC
//   i_reset_n           : async active-low reset
//   i_new_cmd, i_cmd    : command strobe and frame word
//   o_rdy               : idle and not being strobed (combinational)
//   o_data_written_flag : 1-cycle pulse at write completion
//   o_data_read_flag    : 1-cycle pulse when o_r_register_data is updated
//   o_r_register_data   : last captured read data
//   io_mdio             : MDIO line
module mdio
  import mdio_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = PREAMBLE_LEN_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_new_cmd,
  input  logic [FRAME_LEN-1:0] i_cmd,
  output logic                 o_rdy,
  output logic                 o_data_written_flag,
  output logic                 o_data_read_flag,
  output logic [DATA_W-1:0]    o_r_register_data,
  inout  wire                  io_mdio
);

  localparam int unsigned CNT_MAX = (PREAMBLE_LEN > FRAME_LEN) ? PREAMBLE_LEN : FRAME_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [FRAME_LEN-1:0] cmd_q, cmd_nxt;
  logic [DATA_W-1:0]    shift_q, shift_nxt;
  logic [DATA_W-1:0]    rdata_q, rdata_nxt;
  logic                 drv_en_q, drv_en_nxt;
  logic                 drv_bit_q, drv_bit_nxt;
  logic                 wr_flag_q, wr_flag_nxt;
  logic                 rd_flag_q, rd_flag_nxt;
  logic [BIT_IDX_W-1:0] bit_nxt;
  logic                 sample;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cmd_q     <= '0;
      shift_q   <= '0;
      rdata_q   <= '0;
      drv_en_q  <= 1'b0;
      drv_bit_q <= 1'b0;
      wr_flag_q <= 1'b0;
      rd_flag_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cmd_q     <= cmd_nxt;
      shift_q   <= shift_nxt;
      rdata_q   <= rdata_nxt;
      drv_en_q  <= drv_en_nxt;
      drv_bit_q <= drv_bit_nxt;
      wr_flag_q <= wr_flag_nxt;
      rd_flag_q <= rd_flag_nxt;
    end
  end

  // Next-state, read capture and line drive for the coming bit-time
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cmd_nxt     = cmd_q;
    shift_nxt   = shift_q;
    rdata_nxt   = rdata_q;
    wr_flag_nxt = 1'b0;
    rd_flag_nxt = 1'b0;
    drv_en_nxt  = 1'b0;
    drv_bit_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_new_cmd) begin
          cmd_nxt = i_cmd;
          cnt_nxt = '0;
`ifdef MDIO_PREAMBLE_EN
          state_nxt = ST_PREAMBLE;
`else
          state_nxt = ST_FRAME;
`endif
        end
      end
      ST_PREAMBLE: begin
        if (cnt == CNT_W'(PREAMBLE_LEN - 1)) begin
          state_nxt = ST_FRAME;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_FRAME: begin
        // PHY data arrives LSB first in bit-times 16..31
        if (is_read(cmd_q) && cnt >= CNT_W'(DATA_POS)) begin
          shift_nxt = {sample, shift_q[DATA_W-1:1]};
        end
        if (cnt == CNT_W'(FRAME_LEN - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          if (is_read(cmd_q)) begin
            rdata_nxt   = shift_nxt;
            rd_flag_nxt = 1'b1;
          end else begin
            wr_flag_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    bit_nxt = cnt_nxt[BIT_IDX_W-1:0];
    case (state_nxt)
      ST_PREAMBLE: begin
        drv_en_nxt  = 1'b1;
        drv_bit_nxt = 1'b1;
      end
      ST_FRAME: begin
        // Reads hand the line to the PHY from the turnaround onward
        drv_en_nxt  = !is_read(cmd_nxt) || (bit_nxt < BIT_IDX_W'(TA_POS));
        drv_bit_nxt = cmd_nxt[bit_nxt];
      end
      default: ;
    endcase
  end

  mdio_io u_io (
    .drive_en  (drv_en_q),
    .drive_bit (drv_bit_q),
    .sample    (sample),
    .mdio      (io_mdio)
  );

  assign o_rdy               = (state == ST_IDLE) && !i_new_cmd;
  assign o_data_written_flag = wr_flag_q;
  assign o_data_read_flag    = rd_flag_q;
  assign o_r_register_data   = rdata_q;

endmodule

// File: tb/tb_mdio.sv
// Bench for the MDIO master: stimulus issues frames and plays the PHY
// (32x16 register file at PHYAD 0), a monitor checks completion flags
// against a queue of expected responses.
module tb_mdio;

`ifdef MDIO_PREAMBLE_EN
  localparam int PRE = 32;
`else
  localparam int PRE = 0;
`endif
  localparam int NONE = 1000;

  typedef struct {
    bit          rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_cmd = 1'b0;
  logic [31:0] cmd = '0;
  logic        phy_oe = 1'b0;
  logic        phy_bit = 1'b0;
  wire         rdy;
  wire         wflag;
  wire         rflag;
  wire  [15:0] rdata;
  wire         line;
  wire         dut_drv;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] mdl[32];
  logic [15:0] em_reg[32];
  logic [15:0] vals[32];
  logic [15:0] last_rd;

  mdio #(.PREAMBLE_LEN(32)) dut (
    .i_clk               (clk),
    .i_reset_n           (rst_n),
    .i_new_cmd           (new_cmd),
    .i_cmd               (cmd),
    .o_rdy               (rdy),
    .o_data_written_flag (wflag),
    .o_data_read_flag    (rflag),
    .o_r_register_data   (rdata),
    .io_mdio             (line)
  );

  assign line    = phy_oe ? phy_bit : 1'bz;
  assign dut_drv = dut.u_io.drive_en;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wcmd(input logic [4:0] ra, input logic [15:0] d);
    return {d, 2'b01, ra, 5'd0, 2'b10, 2'b10};
  endfunction

  function automatic logic [31:0] rcmd(input logic [4:0] ra);
    return {16'h0000, 2'b01, ra, 5'd0, 2'b01, 2'b10};
  endfunction

  // Issue one command, then act as the PHY for the whole frame.
  task automatic run_frame(input logic [31:0] c, input int inj, input int abort_k);
    int          c0, rdy_hi, drv_bad, pre_bad, k;
    logic [31:0] wb, mask;
    logic        em_rd;
    logic [15:0] em_data;
    logic [4:0]  ra;
    bit          exp_rd;
    exp_rd = (c[3:2] == 2'b01);
    @(negedge clk);
    chk("rdy_idle", 32'(rdy), 32'd1);
    cmd = c;
    new_cmd = 1'b1;
    #1;
    chk("rdy_strobe", 32'(rdy), 32'd0);
    @(posedge clk);
    #1;
    new_cmd = 1'b0;
    c0 = cyc;
    if (abort_k == NONE) begin
      sb.push_back('{rd: exp_rd, data: (exp_rd ? mdl[c[13:9]] : c[31:16]), cyc: c0 + PRE + 32});
      if (!exp_rd) mdl[c[13:9]] = c[31:16];
    end
    rdy_hi = 0; drv_bad = 0; pre_bad = 0; wb = '0; em_rd = 1'b0; em_data = '0; ra = '0;
    for (int j = 0; j < PRE + 32; j++) begin
      @(negedge clk);
      k = j - PRE;
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        chk("abort_release", 32'(dut_drv), 32'd0);
        chk("abort_wflag", 32'(wflag), 32'd0);
        chk("abort_rflag", 32'(rflag), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        chk("abort_rdy", 32'(rdy), 32'd1);
        last_rd = '0;
        phy_oe = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (rdy) rdy_hi++;
      if (k < 0) begin
        if (!dut_drv || line !== 1'b1) pre_bad++;
      end else begin
        if (k < 14 || !em_rd) begin
          wb[k] = line;
          if (!dut_drv) drv_bad++;
        end else if (dut_drv) begin
          drv_bad++;
        end
        if (k == 3) em_rd = (wb[3:2] == 2'b01);
        if (k == 13) begin
          ra = wb[13:9];
          em_data = em_reg[ra];
        end
        if (em_rd && k >= 16) begin
          phy_oe  = 1'b1;
          phy_bit = em_data[k-16];
        end
        if (k == inj) begin
          cmd = 32'h0000_4206;
          new_cmd = 1'b1;
        end
        if (k == inj + 1) new_cmd = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    phy_oe = 1'b0;
    mask = exp_rd ? 32'h0000_3FFF : 32'hFFFF_FFFF;
    chk("wire_bits", wb & mask, c & mask);
    chk("drive_en", drv_bad, 0);
    chk("rdy_busy", rdy_hi, 0);
    chk("preamble", pre_bad, 0);
    if (!em_rd && wb[8:4] == 5'd0) begin
      em_reg[ra] = wb[31:16];
      chk("phy_reg", 32'(em_reg[c[13:9]]), 32'(c[31:16]));
    end
  endtask

  // Monitor: every flag pulse consumes one expected response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (wflag || rflag)) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL flag_unexpected actual wflag=%0b rflag=%0b required=none", wflag, rflag);
        end else begin
          e = sb.pop_front();
          chk("flag_cycle", cyc, e.cyc);
          chk("flag_kind", 32'({wflag, rflag}), e.rd ? 32'd1 : 32'd2);
          if (e.rd) begin
            chk("read_data", 32'(rdata), 32'(e.data));
            last_rd = e.data;
          end else begin
            chk("write_keeps_rdata", 32'(rdata), 32'(last_rd));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      mdl[i] = '0;
      em_reg[i] = '0;
    end
    vals = '{16'h1140, 16'h7949, 16'h0141, 16'h0CC2, 16'h01E1, 16'h45E1, 16'h0007, 16'h2001,
             16'h4D06, 16'h0300, 16'h3C00, 16'h1234, 16'h8001, 16'h00FF, 16'hFF00, 16'h3000,
             16'h0060, 16'hAC00, 16'h5555, 16'hAAAA, 16'h0F0F, 16'hF0F0, 16'h1357, 16'h2468,
             16'h2C00, 16'h9ABC, 16'h0004, 16'h848B, 16'h7FFF, 16'hFFFE, 16'h0101, 16'h0000};
    last_rd = '0;

    repeat (3) @(negedge clk);
    chk("rst_drive", 32'(dut_drv), 32'd0);
    chk("rst_wflag", 32'(wflag), 32'd0);
    chk("rst_rflag", 32'(rflag), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 32'(rdy), 32'd1);
    chk("post_rst_drive", 32'(dut_drv), 32'd0);
    chk("post_rst_rdata", 32'(rdata), 32'd0);

    run_frame(32'h1140_400A, NONE, NONE);
    for (int i = 0; i < 32; i++) run_frame(wcmd(5'(i), vals[i]), NONE, NONE);
    for (int i = 0; i < 32; i++) run_frame(rcmd(5'(i)), NONE, NONE);

    // Strobe with a different command while busy
    run_frame(wcmd(5'd5, 16'hA5A5), 5, NONE);
    run_frame(rcmd(5'd5), NONE, NONE);

    // Reset mid-frame at bit 20
    run_frame(wcmd(5'd6, 16'hBEEF), NONE, 20);
    chk("abort_phy_reg", 32'(em_reg[6]), 32'(vals[6]));
    run_frame(rcmd(5'd6), NONE, NONE);
    run_frame(wcmd(5'd7, 16'h5A5A), NONE, NONE);
    run_frame(rcmd(5'd7), NONE, NONE);

    repeat (4) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
